// File: rtl/inta_sequencer.sv
// -----------------------------------------------------------------------------
// inta_sequencer
//
// Interrupt-acknowledge responder for an 8259-style PIC. It raises INT towards
// the CPU, follows the two-pulse INTA_n handshake, and emits one-cycle
// ack1/ack2 strobes to the in-service register. As a cascade master it drives
// the slave id on the cascade bus. As a slave it compares the cascade bus with
// its own id. Whichever device owns the vector places it on the data bus
// during the second pulse.
//
// Parameters
//   SYNC_STAGES  number of flops in the inta_n / cas_in synchronizers (>= 2)
//
// Ports
//   clk, rst_n    system clock, asynchronous active-low reset
//   irq_valid     resolver has a request above the current in-service priority
//   irq_idx       index of that request
//   inta_n        CPU interrupt acknowledge (active low, asynchronous)
//   sngl, sp      single-PIC mode / master (1) or slave (0) select
//   icw2_base     vector bits [7:3]
//   icw3_cfg      master: slave-present bitmap; slave: [2:0] = own id
//   cas_in        cascade bus input (used by a slave)
//   int_out       INT to the CPU
//   ack1, ack2    one-cycle strobes at the pulse-1 and pulse-2 falling edges
//   irq_idx_lat   index frozen at pulse 1 (7 for a spurious acknowledge)
//   cas_out/oe    cascade id driven by a master, and its enable
//   data_out/oe   vector byte and its enable
// -----------------------------------------------------------------------------
module inta_sequencer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       irq_valid,
  input  logic [2:0] irq_idx,
  input  logic       inta_n,
  input  logic       sngl,
  input  logic       sp,
  input  logic [4:0] icw2_base,
  input  logic [7:0] icw3_cfg,
  input  logic [2:0] cas_in,
  output logic       int_out,
  output logic       ack1,
  output logic       ack2,
  output logic [2:0] irq_idx_lat,
  output logic [2:0] cas_out,
  output logic       cas_oe,
  output logic [7:0] data_out,
  output logic       data_oe
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    P1,
    GAP,
    P2
  } state_t;

  // Configuration snapshot, frozen for the whole acknowledge cycle.
  typedef struct packed {
    logic       sngl;
    logic       sp;
    logic [4:0] base;
    logic [7:0] icw3;
  } cfg_t;

  state_t state, state_nx;
  cfg_t   cfg;

  // ---------------------------------------------------------------------------
  // Synchronizers. The inta_n chain resets to the inactive (high) level so that
  // leaving reset never looks like an acknowledge edge.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] inta_sync;
  logic                   inta_prev;
  logic [2:0]             cas_sync [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inta_sync <= '1;
      inta_prev <= 1'b1;
      for (int i = 0; i < SYNC_STAGES; i++) cas_sync[i] <= '0;
    end else begin
      // NOTE: every sequential assignment is non-blocking, so each stage
      // samples the previous stage's old value and the chain really shifts.
      inta_sync   <= {inta_sync[SYNC_STAGES-2:0], inta_n};
      inta_prev   <= inta_sync[SYNC_STAGES-1];
      cas_sync[0] <= cas_in;
      for (int i = 1; i < SYNC_STAGES; i++) cas_sync[i] <= cas_sync[i-1];
    end
  end

  logic inta_s;
  logic fall;
  logic rise;

  assign inta_s = inta_sync[SYNC_STAGES-1];
  assign fall   = inta_prev & ~inta_s;
  assign rise   = ~inta_prev & inta_s;

  // Configuration follows the pins only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg <= '0;
    end else if (state == IDLE) begin
      cfg <= '{sngl: sngl, sp: sp, base: icw2_base, icw3: icw3_cfg};
    end
  end

  logic is_master;
  logic is_slave;
  logic cas_match;
  logic granted;

  assign is_master = ~cfg.sngl & cfg.sp;
  assign is_slave  = ~cfg.sngl & ~cfg.sp;
  assign cas_match = (cas_sync[SYNC_STAGES-1] == cfg.icw3[2:0]);
  // A slave only takes part in the handshake when the master addressed it;
  // the match is evaluated at each falling edge it affects.
  assign granted   = ~is_slave | cas_match;

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  logic       spurious, spurious_nx;
  logic [2:0] idx_nx;
  logic       ack1_nx, ack2_nx;
  logic       data_oe_nx;
  logic       cas_oe_nx;
  logic [2:0] cas_out_nx;
  logic       int_nx;
  logic [7:0] data_out_nx;

  always_comb begin
    // NOTE: every signal gets a default before the case statement, so no
    // path leaves a value unassigned and no latch is inferred.
    state_nx    = state;
    spurious_nx = spurious;
    idx_nx      = irq_idx_lat;
    ack1_nx     = 1'b0;
    ack2_nx     = 1'b0;
    data_oe_nx  = data_oe;
    cas_oe_nx   = cas_oe;
    cas_out_nx  = cas_out;

    case (state)
      IDLE: begin
        // A fall seen here is an unsolicited INTA and is ignored.
        if (irq_valid) state_nx = REQ;
      end

      REQ: begin
        // INT is held until the CPU answers. A request that disappears
        // before pulse 1 is acknowledged as spurious (index 7).
        if (fall) begin
          state_nx    = P1;
          spurious_nx = ~irq_valid;
          idx_nx      = irq_valid ? irq_idx : 3'd7;
          ack1_nx     = irq_valid & granted;
          cas_oe_nx   = is_master & cfg.icw3[idx_nx];
          cas_out_nx  = cas_oe_nx ? idx_nx : 3'd0;
        end
      end

      P1: begin
        if (rise) state_nx = GAP;
      end

      GAP: begin
        if (fall) begin
          state_nx   = P2;
          ack2_nx    = ~spurious & granted;
          data_oe_nx = cfg.sngl
                     | (is_master & ~cfg.icw3[irq_idx_lat])
                     | (is_slave & cas_match);
        end
      end

      P2: begin
        if (rise) begin
          state_nx   = IDLE;
          data_oe_nx = 1'b0;
          cas_oe_nx  = 1'b0;
          cas_out_nx = 3'd0;
        end
      end

      default: begin
        state_nx   = IDLE;
        data_oe_nx = 1'b0;
        cas_oe_nx  = 1'b0;
        cas_out_nx = 3'd0;
      end
    endcase

    int_nx      = (state_nx == REQ);
    data_out_nx = data_oe_nx ? {cfg.base, idx_nx} : 8'h00;
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs (glitch-free pins)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      spurious    <= 1'b0;
      irq_idx_lat <= 3'd0;
      int_out     <= 1'b0;
      ack1        <= 1'b0;
      ack2        <= 1'b0;
      cas_out     <= 3'd0;
      cas_oe      <= 1'b0;
      data_out    <= 8'h00;
      data_oe     <= 1'b0;
    end else begin
      state       <= state_nx;
      spurious    <= spurious_nx;
      irq_idx_lat <= idx_nx;
      int_out     <= int_nx;
      ack1        <= ack1_nx;
      ack2        <= ack2_nx;
      cas_out     <= cas_out_nx;
      cas_oe      <= cas_oe_nx;
      data_out    <= data_out_nx;
      data_oe     <= data_oe_nx;
    end
  end

endmodule

// File: tb/tb_inta_sequencer.sv
// -----------------------------------------------------------------------------
// tb_inta_sequencer
//
// Directed and randomized acknowledge cycles for inta_sequencer. Expected
// results come from the role rules (single / master / slave), the spurious
// rule and the fixed pin-to-strobe latency. The DUT is never read back to
// form an expectation.
// -----------------------------------------------------------------------------
module tb_inta_sequencer;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       irq_valid;
  logic [2:0] irq_idx;
  logic       inta_n;
  logic       sngl;
  logic       sp;
  logic [4:0] icw2_base;
  logic [7:0] icw3_cfg;
  logic [2:0] cas_in;
  logic       int_out;
  logic       ack1;
  logic       ack2;
  logic [2:0] irq_idx_lat;
  logic [2:0] cas_out;
  logic       cas_oe;
  logic [7:0] data_out;
  logic       data_oe;

  inta_sequencer #(.SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_valid  (irq_valid),
    .irq_idx    (irq_idx),
    .inta_n     (inta_n),
    .sngl       (sngl),
    .sp         (sp),
    .icw2_base  (icw2_base),
    .icw3_cfg   (icw3_cfg),
    .cas_in     (cas_in),
    .int_out    (int_out),
    .ack1       (ack1),
    .ack2       (ack2),
    .irq_idx_lat(irq_idx_lat),
    .cas_out    (cas_out),
    .cas_oe     (cas_oe),
    .data_out   (data_out),
    .data_oe    (data_oe)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Per-cycle observation counters, updated by tick().
  int cyc    = 0;
  int a1_cnt = 0;
  int a2_cnt = 0;
  int a1_at  = 0;
  int a2_at  = 0;
  int viol   = 0;
  bit in_p2  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (ack1 === 1'b1) begin a1_cnt++; a1_at = cyc; end
    if (ack2 === 1'b1) begin a2_cnt++; a2_at = cyc; end
    if (data_oe === 1'b1 && !in_p2) viol++;
    if (data_oe !== 1'b1 && data_out !== 8'h00) viol++;
  endtask

  task automatic clear_counts();
    a1_cnt = 0; a2_cnt = 0; a1_at = 0; a2_at = 0; viol = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_int"},  int_out,     0);
    check({tag, "_ack"},  {ack1, ack2}, 0);
    check({tag, "_idx"},  irq_idx_lat, 0);
    check({tag, "_cas"},  {cas_oe, cas_out}, 0);
    check({tag, "_data"}, {data_oe, data_out}, 0);
  endtask

  // One full acknowledge cycle plus its reference-model expectations.
  task automatic do_txn(input string tag, input bit s_sngl, input bit s_sp,
                        input logic [4:0] s_base, input logic [7:0] s_icw3,
                        input logic [2:0] s_idx, input logic [2:0] s_cas,
                        input bit spur, input bit scramble);
    bit         slave, master, matched, acked, cascade, drive;
    logic [2:0] exp_idx;
    logic [7:0] vec;
    int         low_cyc;

    slave   = !s_sngl && !s_sp;
    master  = !s_sngl && s_sp;
    matched = !slave || (s_cas == s_icw3[2:0]);
    acked   = !spur && matched;
    exp_idx = spur ? 3'd7 : s_idx;
    cascade = master && s_icw3[exp_idx];
    drive   = s_sngl || (master && !s_icw3[exp_idx]) || (slave && matched);
    vec     = {s_base, exp_idx};

    sngl = s_sngl; sp = s_sp; icw2_base = s_base; icw3_cfg = s_icw3;
    cas_in = s_cas; irq_idx = s_idx; irq_valid = 1'b1;
    repeat (4) tick();
    check({tag, "_int_req"}, int_out, 1);
    if (spur) begin
      irq_valid = 1'b0;
      repeat (3) tick();
    end

    clear_counts();
    low_cyc = cyc;
    inta_n  = 1'b0;
    repeat (6) tick();
    check({tag, "_int_p1"}, int_out, 0);
    check({tag, "_ack1_cnt"}, a1_cnt, acked ? 1 : 0);
    if (acked) check({tag, "_ack1_lat"}, a1_at - low_cyc, SYNC + 1);
    check({tag, "_idx_lat"}, irq_idx_lat, exp_idx);
    check({tag, "_cas_p1"}, {cas_oe, cas_out}, cascade ? {1'b1, exp_idx} : 4'h0);

    inta_n = 1'b1;
    if (scramble) begin
      irq_idx   = 3'($urandom);
      irq_valid = 1'($urandom);
      sngl      = 1'($urandom);
      sp        = 1'($urandom);
      icw2_base = 5'($urandom);
      icw3_cfg  = 8'($urandom);
    end
    repeat (4) tick();
    irq_valid = 1'b0;
    check({tag, "_cas_gap"}, cas_oe, cascade);

    in_p2   = 1'b1;
    low_cyc = cyc;
    inta_n  = 1'b0;
    repeat (6) tick();
    check({tag, "_ack2_cnt"}, a2_cnt, acked ? 1 : 0);
    if (acked) check({tag, "_ack2_lat"}, a2_at - low_cyc, SYNC + 1);
    check({tag, "_data_p2"}, {data_oe, data_out}, drive ? {1'b1, vec} : 9'h0);
    check({tag, "_cas_p2"}, {cas_oe, cas_out}, cascade ? {1'b1, exp_idx} : 4'h0);

    inta_n = 1'b1;
    repeat (4) tick();
    in_p2 = 1'b0;
    check({tag, "_end_data"}, {data_oe, data_out}, 0);
    check({tag, "_end_cas"}, {cas_oe, cas_out}, 0);
    check({tag, "_end_int"}, int_out, 0);
    check({tag, "_acks_total"}, {a1_cnt[7:0], a2_cnt[7:0]},
          acked ? 16'h0101 : 16'h0000);
    check({tag, "_oe_viol"}, viol, 0);
  endtask

  initial begin
    rst_n = 1'b0; irq_valid = 1'b0; irq_idx = '0; inta_n = 1'b1;
    sngl = 1'b1; sp = 1'b1; icw2_base = '0; icw3_cfg = '0; cas_in = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #3;
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (3) tick();
    check_all_zero("post_reset");

    // Single PIC, base 08, idx 5 -> vector 45
    do_txn("single", 1, 0, 5'h08, 8'h00, 3'd5, 3'd0, 0, 0);
    // Request withdrawn before pulse 1 -> spurious, vector 47
    do_txn("spurious", 1, 0, 5'h08, 8'h00, 3'd5, 3'd0, 1, 0);
    // Master with slave on IR2 -> cascade id 2, no data
    do_txn("master", 0, 1, 5'h08, 8'h04, 3'd2, 3'd0, 0, 0);
    // Master, IR without slave -> master drives data
    do_txn("master_own", 0, 1, 5'h10, 8'h04, 3'd6, 3'd0, 0, 0);
    // Slave id 3 addressed / not addressed
    do_txn("slave_hit", 0, 0, 5'h0A, 8'h03, 3'd1, 3'd3, 0, 0);
    do_txn("slave_miss", 0, 0, 5'h0A, 8'h03, 3'd1, 3'd5, 0, 0);

    // Unsolicited INTA while idle
    clear_counts();
    irq_valid = 1'b0; sngl = 1'b1;
    inta_n = 1'b0; repeat (6) tick();
    inta_n = 1'b1; repeat (4) tick();
    check("unsol_acks", {a1_cnt[7:0], a2_cnt[7:0]}, 0);
    check("unsol_int", int_out, 0);
    check("unsol_data", {data_oe, data_out}, 0);
    check("unsol_viol", viol, 0);
    do_txn("after_unsol", 1, 1, 5'h1F, 8'h00, 3'd3, 3'd0, 0, 0);

    // Reset asserted during the gap between pulses
    sngl = 1'b0; sp = 1'b1; icw2_base = 5'h08; icw3_cfg = 8'h04;
    irq_idx = 3'd2; irq_valid = 1'b1;
    repeat (4) tick();
    inta_n = 1'b0; repeat (6) tick();
    inta_n = 1'b1; repeat (4) tick();
    check("gap_cas_before_rst", cas_oe, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("gap_rst");
    irq_valid = 1'b0;
    #3 rst_n = 1'b1;
    repeat (3) tick();
    check_all_zero("gap_rst_idle");
    do_txn("after_rst", 1, 0, 5'h08, 8'h00, 3'd5, 3'd0, 0, 0);

    // Randomized cycles; config/request pins are scrambled after pulse 1
    for (int n = 0; n < 24; n++) begin
      bit         r_sngl, r_sp, r_spur;
      logic [7:0] r_icw3;
      logic [2:0] r_cas;
      r_sngl = ($urandom_range(0, 3) == 0);
      r_sp   = 1'($urandom);
      r_spur = ($urandom_range(0, 4) == 0);
      r_icw3 = 8'($urandom);
      r_cas  = $urandom_range(0, 1) ? r_icw3[2:0] : 3'($urandom);
      do_txn("rand", r_sngl, r_sp, 5'($urandom), r_icw3, 3'($urandom),
             r_cas, r_spur, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
